// File: rtl/ram_8_if.sv
// ram_8_if -- bus bundle for the 8 x 16-bit register bank.
//   in      : write data (master -> bank)
//   load    : write strobe (master -> bank)
//   address : word select for write and read (master -> bank)
//   out     : read data for address (bank -> master)
//   busy    : clear sequence in progress, writes ignored (bank -> master)
interface ram_8_if;
  logic [15:0] in;
  logic        load;
  logic [2:0]  address;
  logic [15:0] out;
  logic        busy;

  modport master (output in, load, address, input out, busy);
  modport slave  (input in, load, address, output out, busy);
endinterface

// File: rtl/ram_8.sv
// ram_8 -- eight-word, 16-bit register bank with post-reset clear sequencer.
// Ports:
//   clk   : single clock, rising edge
//   reset : synchronous, active-high; restarts the 8-cycle clear
//   bus   : ram_8_if.slave (in, load, address -> out, busy)
// After reset the sequencer zeroes one word per cycle; busy is high and out
// is forced to zero until all eight words are cleared. Reads are
// combinational through mux_8_way_16.
// Optional build macro RAM_8_BYPASS_EN: while READY with load=1, out shows
// in combinationally (write-through); stored contents are unaffected.

module mux_8_way_16 (
  input  logic [15:0] a, b, c, d, e, f, g, h,
  input  logic [2:0]  sel,
  output logic [15:0] out
);
  always_comb begin
    out = a;
    case (sel)
      3'd0: out = a;
      3'd1: out = b;
      3'd2: out = c;
      3'd3: out = d;
      3'd4: out = e;
      3'd5: out = f;
      3'd6: out = g;
      3'd7: out = h;
      default: out = a;
    endcase
  end
endmodule

module ram_8 (
  input  logic    clk,
  input  logic    reset,
  ram_8_if.slave  bus
);
  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  state_t            state_q;
  logic [2:0]        cnt_q;
  logic              busy_q;
  logic [7:0][15:0]  mem_q, mem_d;
  logic [15:0]       mux_out;

  // Single write port shared by the clear sequencer and the bus. Reset edges
  // never write: the words stay as they were until the clear reaches them.
  always_comb begin
    mem_d = mem_q;
    if (!reset) begin
      if (state_q == CLEAR)
        mem_d[cnt_q] = '0;
      else if (bus.load)
        mem_d[bus.address] = bus.in;
    end
  end

  // Storage has no reset; it is cleared by the sequencer instead.
  always_ff @(posedge clk) mem_q <= mem_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      cnt_q   <= 3'd0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        CLEAR: begin
          if (cnt_q == 3'd7) begin
            state_q <= READY;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        READY: ;
        default: begin
          state_q <= CLEAR;
          cnt_q   <= 3'd0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  mux_8_way_16 u_mux (
    .a(mem_q[0]), .b(mem_q[1]), .c(mem_q[2]), .d(mem_q[3]),
    .e(mem_q[4]), .f(mem_q[5]), .g(mem_q[6]), .h(mem_q[7]),
    .sel(bus.address),
    .out(mux_out)
  );

  assign bus.busy = busy_q;

  always_comb begin
    bus.out = 16'h0000;
    if (state_q == READY) begin
`ifdef RAM_8_BYPASS_EN
      bus.out = bus.load ? bus.in : mux_out;
`else
      bus.out = mux_out;
`endif
    end
  end
endmodule
